// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-ported memory between
// the instruction-fetch port (I) and the load/store port (D).
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              I_READ,
    input  logic [ADDR_W-1:0] I_ADDRESS,
    output logic [DATA_W-1:0] I_READDATA,
    output logic              I_BUSYWAIT,
    input  logic              D_READ,
    input  logic              D_WRITE,
    input  logic [ADDR_W-1:0] D_ADDRESS,
    input  logic [DATA_W-1:0] D_WRITEDATA,
    output logic [DATA_W-1:0] D_READDATA,
    output logic              D_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT
);
    typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, DONE_I, DONE_D} state_t;
    state_t state_q;
    logic   last_q;
    logic   first_q;
    logic   d_req;
    logic   grant_d;
    assign d_req      = D_READ | D_WRITE;
    // last_q high means D was granted last, so I wins the next tie
    assign grant_d    = d_req & (~I_READ | ~last_q);
    assign I_BUSYWAIT = RESET & I_READ & (state_q != DONE_I);
    assign D_BUSYWAIT = RESET & d_req & (state_q != DONE_D);
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            first_q       <= 1'b0;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
            I_READDATA    <= '0;
            D_READDATA    <= '0;
        end else begin
            case (state_q)
                IDLE: if (I_READ | d_req) begin
                    state_q     <= grant_d ? SERVE_D : SERVE_I;
                    last_q      <= grant_d;
                    first_q     <= 1'b1;
                    MEM_READ    <= grant_d ? ~D_WRITE : 1'b1;
                    MEM_WRITE   <= grant_d & D_WRITE;
                    MEM_ADDRESS <= grant_d ? D_ADDRESS : I_ADDRESS;
                    if (grant_d) MEM_WRITEDATA <= D_WRITEDATA;
                end
                // memory raises busywait one cycle late, so the first serve cycle never completes
                SERVE_I, SERVE_D: if (first_q) begin
                    first_q <= 1'b0;
                end else if (!MEM_BUSYWAIT) begin
                    if (MEM_READ && state_q == SERVE_I) I_READDATA <= MEM_READDATA;
                    if (MEM_READ && state_q == SERVE_D) D_READDATA <= MEM_READDATA;
                    MEM_READ  <= 1'b0;
                    MEM_WRITE <= 1'b0;
                    state_q   <= (state_q == SERVE_I) ? DONE_I : DONE_D;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed requests against a fixed-latency memory model, scoreboard-checked.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int N = 3;
    typedef struct {logic w; logic [7:0] a; logic [7:0] wd;} mem_t;
    typedef struct {logic port; logic [7:0] d;} done_t;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       I_READ = 1'b0, D_READ = 1'b0, D_WRITE = 1'b0;
    logic [7:0] I_ADDRESS = '0, D_ADDRESS = '0, D_WRITEDATA = '0;
    logic [7:0] I_READDATA, D_READDATA, MEM_ADDRESS, MEM_WRITEDATA, MEM_READDATA;
    logic       I_BUSYWAIT, D_BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
    logic [7:0] mem [256];
    int         k = 0;
    int         len = 0;
    int         checks = 0;
    int         passes = 0;
    mem_t       mem_q [$];
    done_t      done_q [$];
    mem_t       me;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
        .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    // memory: k counts strobe cycles already elapsed; busy for strobe cycles 2..N
    assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && k >= 1 && k < N;
    assign MEM_READDATA = mem[MEM_ADDRESS];
    always @(posedge CLK) begin
        if (MEM_READ | MEM_WRITE) begin
            if (MEM_WRITE && k >= N) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
            k <= k + 1;
        end else begin
            k <= 0;
        end
    end

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    function automatic void done_chk(input logic p, input logic [7:0] d);
        done_t e;
        if (done_q.size() == 0) begin
            chk(p ? "d_done_unexpected" : "i_done_unexpected", 1, 0);
        end else begin
            e = done_q.pop_front();
            chk(p ? "d_done_order" : "i_done_order", p, e.port);
            chk(p ? "d_readdata" : "i_readdata", d, e.d);
        end
    endfunction

    always @(negedge CLK) begin
        if (!RESET) begin
            len = 0;
        end else if (MEM_READ | MEM_WRITE) begin
            if (len == 0) begin
                if (mem_q.size() == 0) begin
                    chk("mem_unexpected", 1, 0);
                end else begin
                    me = mem_q.pop_front();
                    chk("mem_op", {MEM_READ, MEM_WRITE}, me.w ? 1 : 2);
                    chk("mem_addr", MEM_ADDRESS, me.a);
                    if (me.w) chk("mem_wdata", MEM_WRITEDATA, me.wd);
                end
            end
            len++;
        end else if (len > 0) begin
            chk("strobe_len", len, N + 1);
            len = 0;
        end
    end

    always @(negedge CLK) begin
        if (RESET && I_READ && !I_BUSYWAIT) done_chk(1'b0, I_READDATA);
        if (RESET && (D_READ | D_WRITE) && !D_BUSYWAIT) done_chk(1'b1, D_READDATA);
    end

    task automatic push_m(input logic w, input logic [7:0] a, input logic [7:0] wd);
        mem_t e;
        e.w = w; e.a = a; e.wd = wd;
        mem_q.push_back(e);
    endtask

    task automatic push_d(input logic p, input logic [7:0] d);
        done_t e;
        e.port = p; e.d = d;
        done_q.push_back(e);
    endtask

    task automatic do_i(input logic [7:0] a, input int lat);
        int cyc = 1;
        I_ADDRESS = a;
        I_READ = 1'b1;
        #1 if (RESET) chk("i_bw_immediate", I_BUSYWAIT, 1);
        forever begin
            @(negedge CLK);
            cyc++;
            if (RESET && !I_BUSYWAIT) break;
            if (cyc > 200) begin chk("i_timeout", 0, 1); break; end
        end
        if (lat > 0) chk("i_latency", cyc, lat);
        @(posedge CLK);
        #1 I_READ = 1'b0;
    endtask

    task automatic do_d(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd, input int lat);
        int cyc = 1;
        D_ADDRESS = a;
        D_WRITEDATA = wd;
        D_READ = rd;
        D_WRITE = wr;
        #1 if (RESET) chk("d_bw_immediate", D_BUSYWAIT, 1);
        forever begin
            @(negedge CLK);
            cyc++;
            if (RESET && !D_BUSYWAIT) break;
            if (cyc > 200) begin chk("d_timeout", 0, 1); break; end
        end
        if (lat > 0) chk("d_latency", cyc, lat);
        @(posedge CLK);
        #1 begin D_READ = 1'b0; D_WRITE = 1'b0; end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_mem_read"}, MEM_READ, 0);
        chk({tag, "_mem_write"}, MEM_WRITE, 0);
        chk({tag, "_mem_addr"}, MEM_ADDRESS, 0);
        chk({tag, "_mem_wdata"}, MEM_WRITEDATA, 0);
        chk({tag, "_i_rdata"}, I_READDATA, 0);
        chk({tag, "_d_rdata"}, D_READDATA, 0);
        chk({tag, "_i_bw"}, I_BUSYWAIT, 0);
        chk({tag, "_d_bw"}, D_BUSYWAIT, 0);
    endtask

    task automatic reset_pulse(input string tag);
        for (int j = 0; j < 50 && !(MEM_READ | MEM_WRITE); j++) @(negedge CLK);
        @(posedge CLK);
        @(posedge CLK);
        #3 RESET = 1'b0;
        #1 reset_checks(tag);
        @(negedge CLK);
        #1 RESET = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h5A; mem[8'h11] = 8'hA5; mem[8'h12] = 8'h81; mem[8'h13] = 8'hE7;
        mem[8'h40] = 8'h3C; mem[8'h41] = 8'hC4;
        #2 RESET = 1'b0;
        // both requests pending across reset release: I wins first, then D
        push_m(0, 8'h11, 0); push_m(0, 8'h40, 0);
        push_d(0, 8'hA5);    push_d(1, 8'h3C);
        @(negedge CLK);
        fork
            do_i(8'h11, 0);
            do_d(1, 0, 8'h40, 0, 0);
            begin #1 reset_checks("rst_init"); @(negedge CLK); #1 RESET = 1'b1; end
        join
        // single fetch
        push_m(0, 8'h10, 0); push_d(0, 8'h5A);
        @(negedge CLK);
        do_i(8'h10, N + 3);
        // simultaneous pair with LAST=I: D first, then I
        push_m(0, 8'h41, 0); push_m(0, 8'h12, 0);
        push_d(1, 8'hC4);    push_d(0, 8'h81);
        @(negedge CLK);
        fork
            do_d(1, 0, 8'h41, 0, 0);
            do_i(8'h12, 0);
        join
        // store, with a fetch arriving mid-serve that must wait
        push_m(1, 8'h22, 8'hC3); push_m(0, 8'h10, 0);
        push_d(1, 8'hC4);        push_d(0, 8'h5A);
        @(negedge CLK);
        fork
            do_d(0, 1, 8'h22, 8'hC3, N + 3);
            begin repeat (2) @(negedge CLK); do_i(8'h10, 0); end
        join
        push_m(0, 8'h22, 0); push_d(1, 8'hC3);
        @(negedge CLK);
        do_d(1, 0, 8'h22, 0, N + 3);
        // read and write together is a write
        push_m(1, 8'h23, 8'h99); push_d(1, 8'hC3);
        @(negedge CLK);
        do_d(1, 1, 8'h23, 8'h99, N + 3);
        push_m(0, 8'h23, 0); push_d(1, 8'h99);
        @(negedge CLK);
        do_d(1, 0, 8'h23, 0, N + 3);
        // reset during a fetch: aborted, then reissued after release
        push_m(0, 8'h13, 0); push_m(0, 8'h13, 0); push_d(0, 8'hE7);
        @(negedge CLK);
        fork
            do_i(8'h13, 0);
            reset_pulse("rst_mid_i");
        join
        // reset during a store: aborted, reissued, D_READDATA stays cleared
        push_m(1, 8'h30, 8'h77); push_m(1, 8'h30, 8'h77); push_d(1, 8'h00);
        @(negedge CLK);
        fork
            do_d(0, 1, 8'h30, 8'h77, 0);
            reset_pulse("rst_mid_d");
        join
        push_m(0, 8'h30, 0); push_d(1, 8'h77);
        @(negedge CLK);
        do_d(1, 0, 8'h30, 0, N + 3);
        repeat (4) @(negedge CLK);
        chk("mem_q_drained", mem_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
